johnson_phase_decoder: RTL

JOHNSON_PHASE_DECODER -- requirements
Module: johnson_phase_decoder

---
 rtl/johnson_phase_decoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/johnson_phase_decoder.sv
// Decodes a 4-bit Johnson code into a phase index, tracks sequence lock and
// counts step violations (saturating) and completed revolutions.
module johnson_phase_decoder #(
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [3:0]       q_in,
   output logic [2:0]       phase,
   output logic [7:0]       onehot,
   output logic             code_legal,
   output logic             locked,
   output logic             step_err,
   output logic             wrap_pulse,
   output logic [ERR_W-1:0] err_cnt,
   output logic [15:0]      rev_cnt,
   output logic [1:0]       fsm_state
);

   typedef enum logic [1:0] {
      UNLOCK = 2'd0,
      ACQ    = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] gcnt, gcnt_nxt, gcnt_inc;
   logic       dec_legal;
   logic [2:0] dec_phase, phase_succ;
   logic       is_succ, is_rep, lock_hit;
   logic       err_evt, wrap_evt;

   always_comb begin
      dec_legal = 1'b1;
      dec_phase = 3'd0;
      case (q_in)
         4'b0000: dec_phase = 3'd0;
         4'b0001: dec_phase = 3'd1;
         4'b0011: dec_phase = 3'd2;
         4'b0111: dec_phase = 3'd3;
         4'b1111: dec_phase = 3'd4;
         4'b1110: dec_phase = 3'd5;
         4'b1100: dec_phase = 3'd6;
         4'b1000: dec_phase = 3'd7;
         default: dec_legal = 1'b0;
      endcase
   end

   // phase always holds the last legal sample, so it is the reference for
   // successor/repeat classification in ACQ and LOCKED.
   assign phase_succ = phase + 3'd1;
   assign is_succ    = dec_legal && (dec_phase == phase_succ);
   assign is_rep     = dec_legal && (dec_phase == phase);
   assign gcnt_inc   = gcnt + 4'd1;
   assign lock_hit   = (gcnt_inc == 4'(LOCK_CNT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= UNLOCK;
         gcnt  <= 4'd0;
      end else begin
         state <= state_nxt;
         gcnt  <= gcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gcnt_nxt  = gcnt;
      err_evt   = 1'b0;
      wrap_evt  = 1'b0;
      if (en) begin
         case (state)
            UNLOCK: begin
               if (dec_legal) begin
                  state_nxt = ACQ;
                  gcnt_nxt  = 4'd0;
               end
            end
            ACQ: begin
               if (!dec_legal) begin
                  state_nxt = UNLOCK;
                  gcnt_nxt  = 4'd0;
               end else if (is_succ) begin
                  if (lock_hit) begin
                     state_nxt = LOCKED;
                     gcnt_nxt  = 4'd0;
                  end else begin
                     gcnt_nxt = gcnt_inc;
                  end
               end else if (!is_rep) begin
                  gcnt_nxt = 4'd0;
               end
            end
            LOCKED: begin
               if (!dec_legal) begin
                  err_evt   = 1'b1;
                  state_nxt = UNLOCK;
                  gcnt_nxt  = 4'd0;
               end else if (is_succ) begin
                  wrap_evt = (phase == 3'd7);
               end else if (!is_rep) begin
                  err_evt   = 1'b1;
                  state_nxt = ACQ;
                  gcnt_nxt  = 4'd0;
               end
            end
            default: begin
               state_nxt = UNLOCK;
               gcnt_nxt  = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase      <= 3'd0;
         code_legal <= 1'b0;
         step_err   <= 1'b0;
         wrap_pulse <= 1'b0;
         err_cnt    <= '0;
         rev_cnt    <= 16'd0;
      end else if (en) begin
         code_legal <= dec_legal;
         if (dec_legal) phase <= dec_phase;
         step_err   <= err_evt;
         wrap_pulse <= wrap_evt;
         if (err_evt && (err_cnt != {ERR_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
         if (wrap_evt) rev_cnt <= rev_cnt + 16'd1;
      end else begin
         step_err   <= 1'b0;
         wrap_pulse <= 1'b0;
      end
   end

   always_comb begin
      onehot = 8'd0;
      if (code_legal) onehot[phase] = 1'b1;
      locked    = (state == LOCKED);
      fsm_state = state;
   end

endmodule
